btn_conditioner: RTL and testbench

Multi-channel push-button conditioner that sits between the board's raw button pins (`jump_btn`, `enable_btn`, `rst_btn`) and the game logic in the top level. Each channel does the following:
- synchronises its raw input into `clk`;
- rejects contact bounce with a stable-time counter;
- produces a clean level, single-cycle press and release strobes, and a long-hold flag.

The game state machine and the pause toggle consume the press strobes directly. No further edge detection is needed in the top level.

---
 rtl/btn_pkg.sv | 16 +
 rtl/btn_debounce_chan.sv | 117 +++++++++++
 rtl/btn_conditioner.sv | 34 +++
 tb/tb_btn_conditioner.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM
// encoding and the board's channel assignments.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_e;

  localparam int BTN_JUMP   = 0;
  localparam int BTN_ENABLE = 1;
  localparam int BTN_RST    = 2;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchroniser, stable-time debounce FSM,
// registered press/release strobes and a saturating long-hold detector.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic clk,
  input  logic clr,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_hold
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HOLD_MAX = HCNT_W'(HOLD_CYCLES);

  logic              r_s1, r_s2;
  btn_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [HCNT_W-1:0] r_hcnt, w_hcnt_nxt, w_hcnt_inc;
  logic              r_level, w_level_nxt;
  logic              r_press, w_press_nxt;
  logic              r_release, w_release_nxt;
  logic              r_hold, w_hold_nxt;

  assign w_hcnt_inc = (r_hcnt == HOLD_MAX) ? r_hcnt : r_hcnt + HCNT_W'(1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_hold    <= 1'b0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_hold    <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hcnt_nxt    = r_hcnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    case (r_state)
      IDLE: begin
        if (r_s2) begin
          w_state_nxt = ARM_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      ARM_PRESS: begin
        if (!r_s2) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
          w_hcnt_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        w_hcnt_nxt = w_hcnt_inc;
        w_hold_nxt = r_hold | (w_hcnt_inc == HOLD_MAX);
        if (!r_s2) begin
          w_state_nxt = ARM_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      ARM_RELEASE: begin
        // Hold keeps counting through release bounce so a bounce never restarts it
        w_hcnt_nxt = w_hcnt_inc;
        w_hold_nxt = r_hold | (w_hcnt_inc == HOLD_MAX);
        if (r_s2) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
          w_hold_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_hold    = r_hold;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent debounce channel per
// raw button pin, all in the single clk domain.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_hold
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_chan (
      .clk      (clk),
      .clr      (clr),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g]),
      .o_hold   (btn_hold[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random bouncing input,
// checked against a run-length reference model of the debounce rules.
module tb_btn_conditioner;

  localparam int N = 3;
  localparam int D = 4;
  localparam int H = 20;

  logic         clk = 1'b0;
  logic         clr;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_hold;

  int total = 0;
  int bad   = 0;

  btn_conditioner #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_hold   (btn_hold)
  );

  always #5 clk = ~clk;

  // Reference model: level flips once the synchronised input has disagreed with
  // it for D+1 consecutive edges; hold is "level high for at least H edges since press".
  logic [N-1:0] m_s1, m_s2, m_level, m_press, m_release, m_hold;
  int m_run [N];
  int m_age [N];

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0;
      m_press <= '0; m_release <= '0; m_hold <= '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= 0;
        m_age[i] <= 0;
      end
    end else begin
      m_s1 <= btn_raw;
      m_s2 <= m_s1;
      for (int i = 0; i < N; i++) begin
        automatic int   run  = (m_s2[i] != m_level[i]) ? m_run[i] + 1 : 0;
        automatic logic flip = (run == D + 1);
        automatic logic lvl  = m_level[i] ^ flip;
        automatic int   age  = flip ? 0 : ((m_age[i] < H) ? m_age[i] + 1 : H);
        m_run[i]     <= flip ? 0 : run;
        m_age[i]     <= age;
        m_level[i]   <= lvl;
        m_press[i]   <= flip & lvl;
        m_release[i] <= flip & ~lvl;
        m_hold[i]    <= lvl & ~flip & (age >= H);
      end
    end
  end

  task automatic settle(input int n);
    btn_raw = '0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1;
    btn_raw = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      btn_raw = N'($urandom);
      @(negedge clk);
      if ({btn_level, btn_press, btn_release, btn_hold} !== 12'h000) begin
        bad++;
        $display("FAIL reset_outputs i=%0d got=%h want=000", i, {btn_level, btn_press, btn_release, btn_hold});
      end
      total++;
    end
    btn_raw = '0;
    clr = 1'b0;
    settle(12);
  endtask

  task automatic test_clean_press();
    btn_raw = 3'b001;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_release, m_hold}) begin
        bad++;
        $display("FAIL clean_model i=%0d got=%h want=%h", i, {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_release, m_hold});
      end
      total++;
      if (btn_press[0] !== (i == 6) || btn_level[0] !== (i >= 6) || btn_press[2:1] !== 2'b00 || btn_level[2:1] !== 2'b00) begin
        bad++;
        $display("FAIL clean_press i=%0d got press=%b level=%b want press0=%0d level0=%0d", i, btn_press, btn_level, (i == 6), (i >= 6));
      end
      total++;
    end
    btn_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_release[0] !== (i == 6) || btn_level[0] !== (i < 6)) begin
        bad++;
        $display("FAIL clean_release i=%0d got release=%b level=%b want release0=%0d", i, btn_release, btn_level, (i == 6));
      end
      total++;
    end
    settle(4);
  endtask

  task automatic test_glitch();
    int presses, releases, activity;
    activity = 0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = {1'b0, (i < 4), 1'b0};
      @(negedge clk);
      if (btn_level[1] | btn_press[1] | btn_release[1]) activity++;
    end
    if (activity !== 0) begin
      bad++;
      $display("FAIL glitch_4cyc got activity=%0d want 0", activity);
    end
    total++;
    presses = 0;
    releases = 0;
    for (int i = 0; i < 16; i++) begin
      btn_raw = {1'b0, (i < 5), 1'b0};
      @(negedge clk);
      presses  += int'(btn_press[1]);
      releases += int'(btn_release[1]);
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_release, m_hold}) begin
        bad++;
        $display("FAIL glitch_model i=%0d got=%h want=%h", i, {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_release, m_hold});
      end
      total++;
    end
    if (presses !== 1 || releases !== 1) begin
      bad++;
      $display("FAIL pulse_5cyc got press=%0d release=%0d want 1/1", presses, releases);
    end
    total++;
    settle(8);
  endtask

  task automatic test_bouncy_release();
    int presses, releases, rel_at;
    presses = 0;
    releases = 0;
    rel_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (i < 17)      btn_raw = 3'b001;
      else if (i < 23) btn_raw = {2'b00, ((i - 17) % 2 == 1)};
      else             btn_raw = 3'b000;
      @(negedge clk);
      presses += int'(btn_press[0]);
      if (btn_release[0]) begin
        releases++;
        rel_at = i;
      end
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_release, m_hold}) begin
        bad++;
        $display("FAIL bouncy_model i=%0d got=%h want=%h", i, {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_release, m_hold});
      end
      total++;
    end
    if (presses !== 1 || releases !== 1 || rel_at !== 29) begin
      bad++;
      $display("FAIL bouncy_release got press=%0d release=%0d at=%0d want 1/1 at 29", presses, releases, rel_at);
    end
    total++;
    settle(4);
  endtask

  task automatic test_long_hold();
    int press_at, hold_at, rel_at;
    logic prev_hold;
    press_at = -1;
    hold_at = -1;
    rel_at = -1;
    prev_hold = 1'b0;
    for (int i = 0; i < 56; i++) begin
      btn_raw = {(i < 40), 2'b00};
      @(negedge clk);
      if (btn_press[2]) press_at = i;
      if (btn_hold[2] && hold_at < 0) hold_at = i;
      if (btn_release[2]) begin
        rel_at = i;
        if (btn_hold[2] !== 1'b0 || prev_hold !== 1'b1) begin
          bad++;
          $display("FAIL hold_clear i=%0d got hold=%b prev=%b want 0 prev 1", i, btn_hold[2], prev_hold);
        end
        total++;
      end
      prev_hold = btn_hold[2];
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_release, m_hold}) begin
        bad++;
        $display("FAIL hold_model i=%0d got=%h want=%h", i, {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_release, m_hold});
      end
      total++;
    end
    if (press_at !== 6 || hold_at !== press_at + H || rel_at !== 46) begin
      bad++;
      $display("FAIL hold_timing got press=%0d hold=%0d release=%0d want 6/26/46", press_at, hold_at, rel_at);
    end
    total++;
    settle(4);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i < 3) ? 3'b010 : 3'b011;
      @(negedge clk);
    end
    if (btn_level[1] !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_level got=%b want 1", btn_level[1]);
    end
    total++;
    clr = 1'b1;
    btn_raw = 3'b001;
    #1;
    if ({btn_level, btn_press, btn_release, btn_hold} !== 12'h000) begin
      bad++;
      $display("FAIL reset_async got=%h want=000", {btn_level, btn_press, btn_release, btn_hold});
    end
    total++;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_press !== {2'b00, (i == 6)} || btn_level[0] !== (i >= 6)) begin
        bad++;
        $display("FAIL reset_reprime i=%0d got press=%b level=%b want press0=%0d", i, btn_press, btn_level, (i == 6));
      end
      total++;
    end
    settle(12);
  endtask

  task automatic test_simultaneous();
    btn_raw = 3'b111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_press !== ((i == 6) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL simul_press i=%0d got=%b want=%b", i, btn_press, (i == 6) ? 3'b111 : 3'b000);
      end
      total++;
    end
    btn_raw = 3'b000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (btn_release !== ((i == 6) ? 3'b111 : 3'b000)) begin
        bad++;
        $display("FAIL simul_release i=%0d got=%b want=%b", i, btn_release, (i == 6) ? 3'b111 : 3'b000);
      end
      total++;
    end
    settle(4);
  endtask

  task automatic test_random();
    int remain [N];
    for (int c = 0; c < N; c++) remain[c] = 0;
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < N; c++) begin
        if (remain[c] == 0) begin
          btn_raw[c] = ~btn_raw[c];
          remain[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 32)) : int'($urandom_range(1, 7));
        end
        remain[c]--;
      end
      @(negedge clk);
      if ({btn_level, btn_press, btn_release, btn_hold} !== {m_level, m_press, m_release, m_hold}) begin
        bad++;
        $display("FAIL random_model i=%0d got=%h want=%h", i, {btn_level, btn_press, btn_release, btn_hold}, {m_level, m_press, m_release, m_hold});
      end
      total++;
      if ((btn_press & btn_release) !== 3'b000) begin
        bad++;
        $display("FAIL strobe_excl i=%0d got=%b want 000", i, btn_press & btn_release);
      end
      total++;
    end
    settle(12);
  endtask

  initial begin
    clr = 1'b1;
    btn_raw = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_bouncy_release();
    test_long_hold();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
